ps2_scancode_rx: RTL and testbench

// - Receives PS/2 keyboard frames (start, 8 data LSB-first, odd parity, stop) from the raw
//   ps2_clk/ps2_data pins. Delivers one validated scancode byte per key event to the

---
 rtl/ps2_scancode_rx.sv | 176 +++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, deframes 11-bit frames and
// folds E0/F0 prefix bytes into is_extended/is_break on the following code byte.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err
);

    localparam int FC_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state, next_state;
    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            filt_clk;
    logic [FC_W-1:0] filt_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            brk, ext;
    logic            fall_evt, rx_bit, to_hit, frame_done, timeout, frame_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock only follows the synced pin after FILTER_LEN disagreeing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 != filt_clk) begin
            if (filt_cnt == FC_LAST) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FC_W'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // The falling event fires in the cycle the filter commits to low.
    assign fall_evt   = filt_clk & ~clk_s2 & (filt_cnt == FC_LAST);
    assign rx_bit     = dat_s2;
    assign to_hit     = (to_cnt == TO_LAST) & ~fall_evt;
    assign frame_good = rx_bit & (^{shreg, par_bit});

    always_comb begin
        next_state = state;
        frame_done = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_evt && !rx_bit) next_state = S_DATA;
            end
            S_DATA: begin
                if (to_hit) begin
                    next_state = S_IDLE;
                    timeout    = 1'b1;
                end else if (fall_evt && bit_cnt == 3'd7) begin
                    next_state = S_PARITY;
                end
            end
            S_PARITY: begin
                if (to_hit) begin
                    next_state = S_IDLE;
                    timeout    = 1'b1;
                end else if (fall_evt) begin
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (to_hit) begin
                    next_state = S_IDLE;
                    timeout    = 1'b1;
                end else if (fall_evt) begin
                    next_state = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == S_IDLE || fall_evt) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (state == S_IDLE && fall_evt) begin
                bit_cnt <= '0;
            end else if (state == S_DATA && fall_evt) begin
                shreg[bit_cnt] <= rx_bit;
                bit_cnt        <= bit_cnt + 3'd1;
            end
            if (state == S_PARITY && fall_evt) par_bit <= rx_bit;
        end
    end

    // Prefix bytes only arm flags; the next good code byte consumes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scancode       <= '0;
            scancode_valid <= 1'b0;
            is_break       <= 1'b0;
            is_extended    <= 1'b0;
            frame_err      <= 1'b0;
            brk            <= 1'b0;
            ext            <= 1'b0;
        end else begin
            scancode_valid <= 1'b0;
            frame_err      <= 1'b0;
            if (timeout) begin
                frame_err <= 1'b1;
                brk       <= 1'b0;
                ext       <= 1'b0;
            end else if (frame_done) begin
                if (!frame_good) begin
                    frame_err <= 1'b1;
                    brk       <= 1'b0;
                    ext       <= 1'b0;
                end else if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    scancode       <= shreg;
                    is_break       <= brk;
                    is_extended    <= ext;
                    scancode_valid <= 1'b1;
                    brk            <= 1'b0;
                    ext            <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: a frame-level model predicts each valid/error
// pulse and the held outputs; a negedge compare process checks them every cycle.
module tb_ps2_scancode_rx;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data;
    logic [7:0] scancode;
    logic       scancode_valid, is_break, is_extended, frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int last_fall_cyc = 0;
    int err_cyc = 0;

    // Expected pulse: {is_err, brk, ext, code}
    logic [10:0] exp_q[$];
    logic [7:0]  m_code;
    logic        m_brk, m_ext;
    logic        p_brk, p_ext;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_scancode_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .scancode_valid(scancode_valid), .is_break(is_break),
        .is_extended(is_extended), .frame_err(frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        if (!rst_n) begin
            m_code = '0;
            m_brk  = 1'b0;
            m_ext  = 1'b0;
        end else begin
            chk("valid_err_exclusive", 32'(scancode_valid & frame_err), 32'd0);
            if (scancode_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'({scancode_valid, frame_err}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", 32'(frame_err), 32'(e[10]));
                    if (!e[10]) begin
                        m_code = e[7:0];
                        m_brk  = e[9];
                        m_ext  = e[8];
                    end else begin
                        err_cyc = cyc;
                    end
                end
                if (scancode_valid) n_valid++;
            end
            chk("held_scancode", 32'(scancode), 32'(m_code));
            chk("held_is_break", 32'(is_break), 32'(m_brk));
            chk("held_is_extended", 32'(is_extended), 32'(m_ext));
        end
    end

    task automatic push_err();
        exp_q.push_back({1'b1, 2'b00, 8'h00});
        p_brk = 1'b0;
        p_ext = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
        int ones = $countones({b, par});
        if (stop && (ones % 2 == 1)) begin
            if (b == 8'hE0) p_ext = 1'b1;
            else if (b == 8'hF0) p_brk = 1'b1;
            else begin
                exp_q.push_back({1'b0, p_brk, p_ext, b});
                p_brk = 1'b0;
                p_ext = 1'b0;
            end
        end else begin
            push_err();
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic par, input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(posedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        model_frame(b, par, stop);
        send_bits(b, par, stop, 11);
        wait_drain("pulse_arrived");
        repeat (5) @(posedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1);
    endtask

    task automatic chk_outputs(input string tag, input logic [7:0] code, input logic brk, input logic ext);
        @(negedge clk);
        chk({tag, "_scancode"}, 32'(scancode), 32'(code));
        chk({tag, "_is_break"}, 32'(is_break), 32'(brk));
        chk({tag, "_is_extended"}, 32'(is_extended), 32'(ext));
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b0;
        p_brk    = 1'b0;
        p_ext    = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_scancode", 32'(scancode), 32'd0);
        chk("rst_valid", 32'(scancode_valid), 32'd0);
        chk("rst_is_break", 32'(is_break), 32'd0);
        chk("rst_is_extended", 32'(is_extended), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Plain make code
        send_good(8'h1C);
        chk_outputs("t1", 8'h1C, 1'b0, 1'b0);
        chk("t1_valid_count", 32'(n_valid), 32'd1);

        // Break prefix, then a plain code clears it
        v0 = n_valid;
        send_good(8'hF0);
        send_good(8'h1C);
        chk_outputs("t2", 8'h1C, 1'b1, 1'b0);
        chk("t2_valid_count", 32'(n_valid), 32'(v0 + 1));
        send_good(8'h32);
        chk_outputs("t2b", 8'h32, 1'b0, 1'b0);

        // Extended break
        v0 = n_valid;
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        chk_outputs("t3", 8'h75, 1'b1, 1'b1);
        chk("t3_valid_count", 32'(n_valid), 32'(v0 + 1));

        // Bad parity and bad stop bit leave held outputs alone
        v0 = n_valid;
        send_frame(8'h1C, 1'b1, 1'b1);
        chk_outputs("t4", 8'h75, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk_outputs("t5", 8'h75, 1'b1, 1'b1);
        chk("t45_no_valid", 32'(n_valid), 32'(v0));

        // Clock stops after four data bits
        push_err();
        send_bits(8'h2A, 1'b0, 1'b1, 5);
        wait_drain("timeout_err_arrived");
        chk("timeout_latency_in_window",
            32'((err_cyc - last_fall_cyc >= 100) && (err_cyc - last_fall_cyc <= 115)), 32'd1);
        repeat (5) @(posedge clk);
        send_good(8'h32);
        chk_outputs("t6", 8'h32, 1'b0, 1'b0);

        // Short low glitch on ps2_clk with data low must not start a frame
        ps2_data = 1'b0;
        repeat (5) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(posedge clk);
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        send_good(8'h1C);
        chk_outputs("t7", 8'h1C, 1'b0, 1'b0);

        // Reset in the middle of a frame, with a break prefix armed
        send_good(8'hF0);
        send_bits(8'h55, 1'b1, 1'b1, 4);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst2_scancode", 32'(scancode), 32'd0);
        chk("rst2_valid", 32'(scancode_valid), 32'd0);
        chk("rst2_is_break", 32'(is_break), 32'd0);
        chk("rst2_is_extended", 32'(is_extended), 32'd0);
        chk("rst2_frame_err", 32'(frame_err), 32'd0);
        p_brk = 1'b0;
        p_ext = 1'b0;
        exp_q.delete();
        rst_n = 1'b1;
        repeat (150) @(posedge clk);
        send_good(8'h1C);
        chk_outputs("t8", 8'h1C, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
